pc_step_counter: RTL and testbench

- Parametrised program-counter register for the LC-3 datapath.
- Generalises the fixed +1 incrementer: configurable width, increment step, reset vector, and a load/offset-branch mode.
- Sits between the instruction-fetch address mux and the memory address path.
- Supplies the registered PC and the combinational PC+STEP value to fetch/decode.

---
 rtl/pc_step_counter.sv | 102 ++++++++++
 tb/tb_pc_step_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_step_counter.sv
// LC-3 program counter: LD > BR > INC > hold. Updates take one cycle; PC_INC is combinational.
// Optional PC_TRACE_EN records the source PC of each LD/BR in a small circular buffer.
module pc_step_counter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STEP        = 1,
  parameter int unsigned OFS_W       = 9,
  parameter logic [31:0] RESET_VAL   = 32'h0000_3000,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          inc_i,
  input  logic                          ld_i,
  input  logic [WIDTH-1:0]              ld_val_i,
  input  logic                          br_i,
  input  logic [OFS_W-1:0]              ofs_i,
  output logic [WIDTH-1:0]              pc_o,
  output logic [WIDTH-1:0]              pc_inc_o,
  output logic                          wrap_o
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [WIDTH-1:0]              trace_pc_o,
  output logic [$clog2(TRACE_DEPTH):0]  trace_cnt_o
`endif
);

  // Two spare bits above the widest operand keep carry and borrow distinguishable.
  localparam int unsigned   EW     = ((OFS_W > WIDTH) ? OFS_W : WIDTH) + 2;
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_V  = RESET_VAL[WIDTH-1:0];

  if (WIDTH < 4) begin : g_bad_width
    $error("pc_step_counter: WIDTH must be >= 4");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_step_counter: TRACE_DEPTH must be a power of 2 >= 2");
  end

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   inc_sum;
  logic [EW-1:0]    br_sum;

  assign inc_sum = {1'b0, pc_q} + {1'b0, STEP_V};
  assign br_sum  = EW'(inc_sum) + EW'($signed(ofs_i));

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (ld_i) begin
      pc_d = ld_val_i;
    end else if (br_i) begin
      pc_d   = br_sum[WIDTH-1:0];
      wrap_d = (br_sum[EW-1:WIDTH] != '0);
    end else if (inc_i) begin
      pc_d   = inc_sum[WIDTH-1:0];
      wrap_d = inc_sum[WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= RST_V;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_inc_o = inc_sum[WIDTH-1:0];
  assign wrap_o   = wrap_q;

`ifdef PC_TRACE_EN
  localparam int unsigned IW = $clog2(TRACE_DEPTH);

  logic [WIDTH-1:0] trace_q [TRACE_DEPTH];
  logic [IW-1:0]    wptr_q;
  logic [IW:0]      tcnt_q;
  logic [IW-1:0]    rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
      wptr_q <= '0;
      tcnt_q <= '0;
    end else if (ld_i || br_i) begin
      trace_q[wptr_q] <= pc_q;
      wptr_q          <= wptr_q + IW'(1);
      if (tcnt_q != (IW+1)'(TRACE_DEPTH)) tcnt_q <= tcnt_q + (IW+1)'(1);
    end
  end

  // Newest entry sits just behind the write pointer.
  assign rd_ptr      = wptr_q - trace_idx_i - IW'(1);
  assign trace_pc_o  = ({1'b0, trace_idx_i} < tcnt_q) ? trace_q[rd_ptr] : '0;
  assign trace_cnt_o = tcnt_q;
`endif

endmodule

// File: tb/tb_pc_step_counter.sv
// Directed bench for pc_step_counter: default 16-bit instance plus an 8-bit STEP=2 instance.
module tb_pc_step_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_inc, a_ld, a_br;
  logic [15:0] a_ld_val, a_pc, a_pc_inc;
  logic [8:0]  a_ofs;
  logic        a_wrap;

  logic        b_inc, b_ld, b_br;
  logic [7:0]  b_ld_val, b_pc, b_pc_inc;
  logic [8:0]  b_ofs;
  logic        b_wrap;

`ifdef PC_TRACE_EN
  logic [1:0]  a_tidx, b_tidx;
  logic [15:0] a_tpc;
  logic [7:0]  b_tpc;
  logic [2:0]  a_tcnt, b_tcnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  pc_step_counter u_a (
    .clk_i(clk), .rst_i(rst), .inc_i(a_inc), .ld_i(a_ld), .ld_val_i(a_ld_val),
    .br_i(a_br), .ofs_i(a_ofs), .pc_o(a_pc), .pc_inc_o(a_pc_inc), .wrap_o(a_wrap)
`ifdef PC_TRACE_EN
    , .trace_idx_i(a_tidx), .trace_pc_o(a_tpc), .trace_cnt_o(a_tcnt)
`endif
  );

  pc_step_counter #(.WIDTH(8), .STEP(2), .RESET_VAL(32'h0000_00FE)) u_b (
    .clk_i(clk), .rst_i(rst), .inc_i(b_inc), .ld_i(b_ld), .ld_val_i(b_ld_val),
    .br_i(b_br), .ofs_i(b_ofs), .pc_o(b_pc), .pc_inc_o(b_pc_inc), .wrap_o(b_wrap)
`ifdef PC_TRACE_EN
    , .trace_idx_i(b_tidx), .trace_pc_o(b_tpc), .trace_cnt_o(b_tcnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_inc = 1'b1; a_ld = 1'b0; a_br = 1'b0; a_ld_val = '0; a_ofs = '0;
    b_inc = 1'b0; b_ld = 1'b0; b_br = 1'b0; b_ld_val = '0; b_ofs = '0;
`ifdef PC_TRACE_EN
    a_tidx = '0; b_tidx = '0;
`endif
    #2;
    check("rst_pc",      a_pc,     32'h3000);
    check("rst_wrap",    a_wrap,   32'h0);
    check("rst_pc_inc",  a_pc_inc, 32'h3001);
    check("rst_b_pc",    b_pc,     32'hFE);
    check("rst_b_pc_inc", b_pc_inc, 32'h00);
    step();
    check("rst_hold_inc", a_pc,    32'h3000);
`ifdef PC_TRACE_EN
    check("rst_tcnt",    a_tcnt,   32'h0);
`endif

    rst = 1'b0;
    step(); step(); step();
    check("inc3_pc",   a_pc,   32'h3003);
    check("inc3_wrap", a_wrap, 32'h0);

    // 8-bit instance: STEP=2 wraps from FE, then branch back by -3
    a_inc = 1'b0;
    b_inc = 1'b1;
    step();
    check("b_inc_pc",     b_pc,     32'h00);
    check("b_inc_wrap",   b_wrap,   32'h1);
    check("b_inc_pc_inc", b_pc_inc, 32'h02);
    check("a_hold_pc",    a_pc,     32'h3003);
    b_inc = 1'b0; b_br = 1'b1; b_ofs = 9'h1FD;
    step();
    check("b_br_pc",   b_pc,   32'hFF);
    check("b_br_wrap", b_wrap, 32'h1);
    b_br = 1'b0;
    step();
    check("b_hold_pc",   b_pc,   32'hFF);
    check("b_hold_wrap", b_wrap, 32'h0);

    // 16-bit wrap through FFFF
    a_ld = 1'b1; a_ld_val = 16'hFFFF;
    step();
    check("ld_ffff_pc",     a_pc,     32'hFFFF);
    check("ld_ffff_wrap",   a_wrap,   32'h0);
    check("ld_ffff_pc_inc", a_pc_inc, 32'h0000);
    a_ld = 1'b0; a_inc = 1'b1;
    step();
    check("wrap_pc",     a_pc,     32'h0000);
    check("wrap_wrap",   a_wrap,   32'h1);
    check("wrap_pc_inc", a_pc_inc, 32'h0001);
    a_inc = 1'b0;
    step();
    check("wrap_clear_wrap", a_wrap, 32'h0);
    check("wrap_clear_pc",   a_pc,   32'h0000);

    // Branches relative to PC+1
    a_ld = 1'b1; a_ld_val = 16'h3010;
    step();
    a_ld = 1'b0; a_br = 1'b1; a_ofs = 9'h1F0;
    step();
    check("br_neg_pc",   a_pc,   32'h3001);
    check("br_neg_wrap", a_wrap, 32'h0);
    a_br = 1'b0; a_ld = 1'b1; a_ld_val = 16'h3010;
    step();
    a_ld = 1'b0; a_br = 1'b1; a_ofs = 9'h0FF;
    step();
    check("br_pos_pc", a_pc, 32'h3110);

    // Priority LD > BR > INC
    a_br = 1'b0; a_ld = 1'b1; a_ld_val = 16'h3000;
    step();
    a_ld = 1'b1; a_ld_val = 16'h4000; a_br = 1'b1; a_inc = 1'b1; a_ofs = 9'h000;
    step();
    check("prio_ld_pc", a_pc, 32'h4000);
    a_ld = 1'b0;
    step();
    check("prio_br_pc", a_pc, 32'h4001);
    a_br = 1'b0;
    step();
    check("prio_inc_pc", a_pc, 32'h4002);

    // Reset mid-sequence is asynchronous and drops the pending increment
    #2 rst = 1'b1;
    #1;
    check("midrst_pc",   a_pc,   32'h3000);
    check("midrst_b_pc", b_pc,   32'hFE);
    step();
    check("midrst_hold_pc", a_pc, 32'h3000);
    rst = 1'b0; a_inc = 1'b0;

    // Five branches of +4 from 3000: sources 3000, 3005, 300A, 300F, 3014
    a_br = 1'b1; a_ofs = 9'h004;
    step();
    check("trc_first_pc", a_pc, 32'h3005);
`ifdef PC_TRACE_EN
    check("trc_cnt1", a_tcnt, 32'h1);
    a_tidx = 2'd0; #1;
    check("trc1_idx0", a_tpc, 32'h3000);
    a_tidx = 2'd1; #1;
    check("trc1_idx1_empty", a_tpc, 32'h0);
`endif
    step(); step(); step(); step();
    a_br = 1'b0;
    check("trc_last_pc", a_pc, 32'h3019);
`ifdef PC_TRACE_EN
    check("trc_cnt_sat", a_tcnt, 32'h4);
    a_tidx = 2'd0; #1; check("trc_idx0", a_tpc, 32'h3014);
    a_tidx = 2'd1; #1; check("trc_idx1", a_tpc, 32'h300F);
    a_tidx = 2'd2; #1; check("trc_idx2", a_tpc, 32'h300A);
    a_tidx = 2'd3; #1; check("trc_idx3", a_tpc, 32'h3005);
    check("trc_b_cnt", b_tcnt, 32'h0);
`endif
    rst = 1'b1;
    #1;
    check("final_rst_pc", a_pc, 32'h3000);
`ifdef PC_TRACE_EN
    check("final_rst_tcnt", a_tcnt, 32'h0);
    check("final_rst_tpc",  a_tpc,  32'h0);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
